// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : proc_pkg
// Purpose : shared run-control types: FSM states, command ops, halt causes
// Rev     : 1.0
// ============================================================================
package proc_pkg;

  localparam int INSN_W = 8;

  typedef enum logic [2:0] {
    c_st_idle   = 3'd0,
    c_st_load   = 3'd1,
    c_st_run    = 3'd2,
    c_st_step   = 3'd3,
    c_st_halted = 3'd4
  } state_t;

  localparam logic [1:0] c_op_load = 2'd0;
  localparam logic [1:0] c_op_run  = 2'd1;
  localparam logic [1:0] c_op_step = 2'd2;
  localparam logic [1:0] c_op_halt = 2'd3;

  localparam logic [1:0] c_hr_cmd    = 2'd0;
  localparam logic [1:0] c_hr_bp     = 2'd1;
  localparam logic [1:0] c_hr_budget = 2'd2;
  localparam logic [1:0] c_hr_loop   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/proc_loader.sv
`default_nettype none
// ============================================================================
// Module  : proc_loader
// Purpose : program-load byte counter and instruction-memory write port
// Rev     : 1.0
// ============================================================================
module proc_loader
  import proc_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        count,
  input  logic              ld_valid,
  input  logic [INSN_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [INSN_W-1:0] imem_wdata
);

  // wide enough for both an 8-bit count and a full 2**ADDR_W load
  localparam int REM_W = (ADDR_W >= 8) ? ADDR_W + 1 : 9;

  logic [REM_W-1:0]  r_remaining;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ld_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [INSN_W-1:0] r_wdata;
  logic              w_hs;

  assign w_hs = ld_valid && r_ld_ready;
  assign last = w_hs && (r_remaining == REM_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_addr      <= '0;
      r_ld_ready  <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
    end else begin
      r_we <= w_hs;
      if (start) begin
        r_ld_ready  <= 1'b1;
        r_addr      <= '0;
        r_remaining <= (count == 8'd0) ? REM_W'(2 ** ADDR_W) : REM_W'(count);
      end else if (w_hs) begin
        r_waddr     <= r_addr;
        r_wdata     <= ld_data;
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
        if (last) r_ld_ready <= 1'b0;
      end
    end
  end

  assign ld_ready   = r_ld_ready;
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : proc_run_ctrl
// Purpose : run-control sequencer: program load, gated execution, halt detect
// Rev     : 1.0
// ============================================================================
module proc_run_ctrl
  import proc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int CYC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_arg,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [INSN_W-1:0] ld_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [INSN_W-1:0] imem_wdata,
  output logic              core_rst_n,
  output logic              core_en,
  input  logic [ADDR_W-1:0] core_pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [2:0]        state,
  output logic [1:0]        halt_reason,
  output logic [CYC_W-1:0]  cycle_count
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_cmd_ready;
  logic              r_core_en;
  logic              r_core_rst_n;
  logic [1:0]        r_halt_reason;
  logic [CYC_W-1:0]  r_cycle_count;
  logic [7:0]        r_budget;
  logic [ADDR_W-1:0] r_prev_pc;
  logic              r_first;

  logic              w_cmd_hs;
  logic              w_idle_like;
  logic              w_load_start;
  logic              w_run_start;
  logic              w_ld_last;
  logic              w_halt;
  logic [1:0]        w_halt_cause;
  logic              w_enter_halt;
  logic              w_cmd_ready_d;
  logic              w_core_en_d;
  logic              w_core_rst_n_d;

  assign w_cmd_hs     = cmd_valid && r_cmd_ready;
  assign w_idle_like  = (r_state == c_st_idle) || (r_state == c_st_halted);
  assign w_load_start = w_idle_like && w_cmd_hs && (cmd_op == c_op_load);
  assign w_run_start  = w_idle_like && w_cmd_hs && (cmd_op == c_op_run);

  proc_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk        (clk),
    .rst_n      (reset),
    .start      (w_load_start),
    .count      (cmd_arg),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .last       (w_ld_last),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  // First RUN cycle ignores breakpoint and self-loop so RUN can leave a breakpoint
  always_comb begin
    w_halt       = 1'b1;
    w_halt_cause = c_hr_cmd;
    if (w_cmd_hs && (cmd_op == c_op_halt))              w_halt_cause = c_hr_cmd;
    else if (!r_first && bp_en && (core_pc == bp_addr)) w_halt_cause = c_hr_bp;
    else if (r_budget == 8'd1)                          w_halt_cause = c_hr_budget;
    else if (!r_first && (core_pc == r_prev_pc))        w_halt_cause = c_hr_loop;
    else                                                w_halt       = 1'b0;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle, c_st_halted: begin
        if (w_cmd_hs) begin
          case (cmd_op)
            c_op_load: w_next_state = c_st_load;
            c_op_run:  w_next_state = c_st_run;
            c_op_step: w_next_state = c_st_step;
            default:   w_next_state = c_st_halted;
          endcase
        end
      end
      c_st_load: if (w_ld_last) w_next_state = c_st_idle;
      c_st_run:  if (w_halt)    w_next_state = c_st_halted;
      c_st_step: w_next_state = c_st_halted;
      default:   w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    w_cmd_ready_d  = (w_next_state == c_st_idle) || (w_next_state == c_st_halted) ||
                     (w_next_state == c_st_run);
    w_core_en_d    = (w_next_state == c_st_run) || (w_next_state == c_st_step);
    w_core_rst_n_d = (w_next_state != c_st_load);
    w_enter_halt   = (w_next_state == c_st_halted) &&
                     ((r_state != c_st_halted) || w_cmd_hs);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd_ready   <= 1'b0;
      r_core_en     <= 1'b0;
      r_core_rst_n  <= 1'b0;
      r_halt_reason <= c_hr_cmd;
      r_cycle_count <= '0;
      r_budget      <= '0;
      r_prev_pc     <= '0;
      r_first       <= 1'b0;
    end else begin
      r_cmd_ready  <= w_cmd_ready_d;
      r_core_en    <= w_core_en_d;
      r_core_rst_n <= w_core_rst_n_d;
      if (w_enter_halt)
        r_halt_reason <= (r_state == c_st_run) ? w_halt_cause : c_hr_cmd;
      if (w_load_start)
        r_cycle_count <= '0;
      else if (r_core_en && (r_cycle_count != '1))
        r_cycle_count <= r_cycle_count + 1'b1;
      if (w_run_start) begin
        r_budget <= cmd_arg;
        r_first  <= 1'b1;
      end else if (r_core_en) begin
        r_first   <= 1'b0;
        r_prev_pc <= core_pc;
        if (r_budget != 8'd0) r_budget <= r_budget - 1'b1;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign core_en     = r_core_en;
  assign core_rst_n  = r_core_rst_n;
  assign state       = r_state;
  assign halt_reason = r_halt_reason;
  assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire
